// File: rtl/lcd_text_display.sv
// lcd_text_display: HD44780-compatible 16x2 LCD driver, 4-bit write-only.
// Initialises the panel, then refreshes both lines forever from a
// 32-character string (char 0 in the top byte of strdata).
// Build option: define LCD_CURSOR_BLINK_EN to turn cursor and blink on.
module lcd_text_display #(
  parameter int unsigned POWERUP_WAIT    = 750000,
  parameter int unsigned INIT_WAIT_LONG  = 205000,
  parameter int unsigned INIT_WAIT_SHORT = 5000,
  parameter int unsigned E_SETUP         = 2,
  parameter int unsigned E_PULSE         = 12,
  parameter int unsigned E_HOLD          = 2,
  parameter int unsigned CMD_WAIT        = 2000,
  parameter int unsigned CLEAR_WAIT      = 82000
) (
  input  logic         CCLK,
  input  logic         cls,
  input  logic [255:0] strdata,
  output logic         rslcd,
  output logic         rwlcd,
  output logic         elcd,
  output logic [3:0]   lcdd
);

`ifdef LCD_CURSOR_BLINK_EN
  localparam logic [7:0] DISP_CMD = 8'h0F;
`else
  localparam logic [7:0] DISP_CMD = 8'h0C;
`endif

  localparam int unsigned MAX_A = (POWERUP_WAIT > INIT_WAIT_LONG) ? POWERUP_WAIT : INIT_WAIT_LONG;
  localparam int unsigned MAX_B = (INIT_WAIT_SHORT > CLEAR_WAIT) ? INIT_WAIT_SHORT : CLEAR_WAIT;
  localparam int unsigned MAX_C = (CMD_WAIT > E_PULSE) ? CMD_WAIT : E_PULSE;
  localparam int unsigned MAX_D = (E_SETUP > E_HOLD) ? E_SETUP : E_HOLD;
  localparam int unsigned MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_CD = (MAX_C > MAX_D) ? MAX_C : MAX_D;
  localparam int unsigned MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  // One spare bit so count+1 never wraps before reaching the longest phase.
  localparam int unsigned CW = $clog2(MAX_ALL + 1) + 1;

  typedef logic [CW-1:0] cnt_t;

  typedef enum logic [2:0] {
    T_POWERUP, T_INIT, T_CONFIG, T_ADDR1, T_LINE1, T_ADDR2, T_LINE2
  } top_t;

  typedef enum logic [2:0] {
    P_IDLE, P_SETUP, P_PULSE, P_HOLD, P_WAIT
  } ph_t;

  top_t       r_top, w_top, w_src;
  ph_t        r_ph, w_ph;
  cnt_t       r_cnt, w_cnt, r_wait, w_wait, w_len;
  logic [3:0] r_idx, w_idx, r_nib, w_nib;
  logic       r_hi, w_hi, r_rs, w_rs, r_e, w_e;
  logic [7:0] r_byte, w_byte, w_bsel, w_char;
  logic [4:0] w_kinv;
  logic       w_done, w_issue;

  // Next-state: phase timing, nibble sequencing and byte capture.
  always_comb begin
    w_top   = r_top;
    w_ph    = r_ph;
    w_cnt   = r_cnt + cnt_t'(1);
    w_idx   = r_idx;
    w_hi    = r_hi;
    w_byte  = r_byte;
    w_rs    = r_rs;
    w_nib   = r_nib;
    w_wait  = r_wait;
    w_issue = 1'b0;
    w_src   = (r_top == T_POWERUP) ? T_INIT : r_top;
    w_kinv  = 5'd31 - {(w_src == T_LINE2), r_idx};
    w_char  = strdata[{w_kinv, 3'b000} +: 8];

    case (w_src)
      T_CONFIG: begin
        case (r_idx[1:0])
          2'd0:    w_bsel = 8'h28;
          2'd1:    w_bsel = DISP_CMD;
          2'd2:    w_bsel = 8'h06;
          default: w_bsel = 8'h01;
        endcase
      end
      T_ADDR1: w_bsel = 8'h80;
      T_ADDR2: w_bsel = 8'hC0;
      default: w_bsel = w_char;
    endcase

    case (r_ph)
      P_IDLE:  w_len = cnt_t'(POWERUP_WAIT);
      P_SETUP: w_len = cnt_t'(E_SETUP);
      P_PULSE: w_len = cnt_t'(E_PULSE);
      P_HOLD:  w_len = cnt_t'(E_HOLD);
      default: w_len = r_wait;
    endcase
    w_done = ((r_cnt + cnt_t'(1)) >= w_len);

    // Zero-length phases are skipped so a 0 parameter costs no cycles.
    if (w_done) begin
      w_cnt = '0;
      case (r_ph)
        P_IDLE: w_issue = 1'b1;
        P_SETUP: begin
          if (E_PULSE != 0)      w_ph = P_PULSE;
          else if (E_HOLD != 0)  w_ph = P_HOLD;
          else if (r_wait != '0) w_ph = P_WAIT;
          else                   w_issue = 1'b1;
        end
        P_PULSE: begin
          if (E_HOLD != 0)       w_ph = P_HOLD;
          else if (r_wait != '0) w_ph = P_WAIT;
          else                   w_issue = 1'b1;
        end
        P_HOLD: begin
          if (r_wait != '0) w_ph = P_WAIT;
          else              w_issue = 1'b1;
        end
        default: w_issue = 1'b1;
      endcase
    end

    if (w_issue) begin
      w_cnt = '0;
      if (w_src == T_INIT) begin
        w_rs  = 1'b0;
        w_nib = (r_idx == 4'd3) ? 4'h2 : 4'h3;
        case (r_idx[1:0])
          2'd0:    w_wait = cnt_t'(INIT_WAIT_LONG);
          2'd1:    w_wait = cnt_t'(INIT_WAIT_SHORT);
          default: w_wait = cnt_t'(CMD_WAIT);
        endcase
        if (r_idx == 4'd3) begin
          w_top = T_CONFIG;
          w_idx = '0;
          w_hi  = 1'b1;
        end else begin
          w_top = T_INIT;
          w_idx = r_idx + 4'd1;
        end
      end else if (r_hi) begin
        // High nibble: capture the whole byte so the low nibble cannot tear.
        w_byte = w_bsel;
        w_nib  = w_bsel[7:4];
        w_rs   = (w_src == T_LINE1) || (w_src == T_LINE2);
        w_wait = '0;
        w_hi   = 1'b0;
      end else begin
        w_nib  = r_byte[3:0];
        w_wait = ((r_top == T_CONFIG) && (r_idx == 4'd3)) ? cnt_t'(CLEAR_WAIT) : cnt_t'(CMD_WAIT);
        w_hi   = 1'b1;
        case (r_top)
          T_CONFIG: begin
            if (r_idx == 4'd3) begin w_top = T_ADDR1; w_idx = '0; end
            else w_idx = r_idx + 4'd1;
          end
          T_ADDR1: begin w_top = T_LINE1; w_idx = '0; end
          T_LINE1: begin
            if (r_idx == 4'd15) begin w_top = T_ADDR2; w_idx = '0; end
            else w_idx = r_idx + 4'd1;
          end
          T_ADDR2: begin w_top = T_LINE2; w_idx = '0; end
          T_LINE2: begin
            if (r_idx == 4'd15) begin w_top = T_ADDR1; w_idx = '0; end
            else w_idx = r_idx + 4'd1;
          end
          default: w_top = r_top;
        endcase
      end
      if (E_SETUP != 0)      w_ph = P_SETUP;
      else if (E_PULSE != 0) w_ph = P_PULSE;
      else if (E_HOLD != 0)  w_ph = P_HOLD;
      else if (w_wait != '0) w_ph = P_WAIT;
      else                   w_ph = P_SETUP;
    end

    w_e = (w_ph == P_PULSE);
  end

  // State and output registers; cls restarts from power-up.
  always_ff @(posedge CCLK) begin
    if (cls) begin
      r_top  <= T_POWERUP;
      r_ph   <= P_IDLE;
      r_cnt  <= '0;
      r_idx  <= '0;
      r_hi   <= 1'b1;
      r_byte <= '0;
      r_rs   <= 1'b0;
      r_nib  <= '0;
      r_e    <= 1'b0;
      r_wait <= '0;
    end else begin
      r_top  <= w_top;
      r_ph   <= w_ph;
      r_cnt  <= w_cnt;
      r_idx  <= w_idx;
      r_hi   <= w_hi;
      r_byte <= w_byte;
      r_rs   <= w_rs;
      r_nib  <= w_nib;
      r_e    <= w_e;
      r_wait <= w_wait;
    end
  end

  assign rslcd = r_rs;
  assign rwlcd = 1'b0;
  assign elcd  = r_e;
  assign lcdd  = r_nib;

endmodule

// File: tb/tb_lcd_text_display.sv
// Bench for lcd_text_display with short timing parameters. Expected nibble
// order comes from the command/character tables; expected strobe times
// come from the setup/pulse/hold/wait arithmetic.
module tb_lcd_text_display;

  localparam int unsigned P_PW  = 10;
  localparam int unsigned P_IWL = 8;
  localparam int unsigned P_IWS = 4;
  localparam int unsigned P_ES  = 1;
  localparam int unsigned P_EP  = 2;
  localparam int unsigned P_EH  = 1;
  localparam int unsigned P_CMD = 4;
  localparam int unsigned P_CLR = 8;

`ifdef LCD_CURSOR_BLINK_EN
  localparam logic [7:0] DISP = 8'h0F;
`else
  localparam logic [7:0] DISP = 8'h0C;
`endif

  logic         CCLK = 1'b0;
  logic         cls;
  logic [255:0] strdata;
  logic         rslcd, rwlcd, elcd;
  logic [3:0]   lcdd;

  lcd_text_display #(
    .POWERUP_WAIT(P_PW), .INIT_WAIT_LONG(P_IWL), .INIT_WAIT_SHORT(P_IWS),
    .E_SETUP(P_ES), .E_PULSE(P_EP), .E_HOLD(P_EH),
    .CMD_WAIT(P_CMD), .CLEAR_WAIT(P_CLR)
  ) dut (
    .CCLK(CCLK), .cls(cls), .strdata(strdata),
    .rslcd(rslcd), .rwlcd(rwlcd), .elcd(elcd), .lcdd(lcdd)
  );

  always #5 CCLK = ~CCLK;

  int cyc = 0;
  always @(posedge CCLK) cyc <= cyc + 1;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic       prev_e;
  logic [3:0] prev_lcdd;
  int         t_next;
  bit         dead;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] char_of(input logic [255:0] s, input int k);
    return s[255 - 8*k -: 8];
  endfunction

  // Wait for the next E strobe and check its nibble, RS/RW, timing and shape.
  task automatic exp_nib(input string tag, input logic rs_e, input logic [3:0] nib_e,
                         input int unsigned wait_e);
    int n, hi, t_rise;
    logic found, rs_r;
    logic [3:0] nib_r;
    if (dead) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    found = 1'b0;
    n = 0;
    while (!found && n < 400) begin
      @(negedge CCLK);
      n++;
      if (elcd === 1'b1 && prev_e === 1'b0) found = 1'b1;
      else begin
        prev_e    = elcd;
        prev_lcdd = lcdd;
      end
    end
    if (!found) begin
      dead = 1'b1;
      check({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    t_rise = cyc;
    check({tag, "_nib"}, 32'(lcdd), 32'(nib_e));
    check({tag, "_rsrw"}, 32'({rslcd, rwlcd}), 32'({rs_e, 1'b0}));
    check({tag, "_time"}, 32'(t_rise), 32'(t_next));
    check({tag, "_setup"}, 32'(prev_lcdd), 32'(lcdd));
    nib_r = lcdd;
    rs_r  = rslcd;
    hi = 1;
    while (elcd === 1'b1 && hi < 100) begin
      @(negedge CCLK);
      if (elcd === 1'b1) hi++;
    end
    check({tag, "_elen"}, 32'(hi), 32'(P_EP));
    check({tag, "_hold"}, 32'({rslcd, lcdd}), 32'({rs_r, nib_r}));
    prev_e    = elcd;
    prev_lcdd = lcdd;
    t_next    = t_rise + int'(P_EP + P_EH + wait_e + P_ES);
  endtask

  task automatic exp_cmd(input string tag, input logic [7:0] b, input int unsigned wait_e);
    exp_nib({tag, "_hi"}, 1'b0, b[7:4], 0);
    exp_nib({tag, "_lo"}, 1'b0, b[3:0], wait_e);
  endtask

  // One refresh frame. s_new is applied during the 0x80 command; if tear_j
  // is in range, s_tear is applied between the two nibbles of char tear_j.
  task automatic run_frame(input logic [255:0] s_new, input int tear_j, input logic [255:0] s_tear);
    logic [7:0] exp_b [32];
    for (int k = 0; k < 32; k++)
      exp_b[k] = (tear_j >= 0 && k > tear_j) ? char_of(s_tear, k) : char_of(s_new, k);
    exp_nib("addr1_hi", 1'b0, 4'h8, 0);
    strdata = s_new;
    exp_nib("addr1_lo", 1'b0, 4'h0, P_CMD);
    for (int k = 0; k < 32; k++) begin
      if (k == 16) exp_cmd("addr2", 8'hC0, P_CMD);
      exp_nib("data_hi", 1'b1, exp_b[k][7:4], 0);
      if (k == tear_j) strdata = s_tear;
      exp_nib("data_lo", 1'b1, exp_b[k][3:0], P_CMD);
    end
  endtask

  task automatic rand_str(output logic [255:0] s);
    for (int i = 0; i < 8; i++) s[32*i +: 32] = $urandom();
  endtask

  initial begin
    logic [255:0] s0, s1, s2, s3, s4;
    logic found;
    int tj;
    s0 = "01234567 00 0123f01d01e01m01w01 ";
    prev_e    = 1'b0;
    prev_lcdd = 4'h0;
    dead      = 1'b0;
    cls       = 1'b1;
    strdata   = s0;

    repeat (3) begin
      @(negedge CCLK);
      check("reset_out", 32'({elcd, rslcd, rwlcd, lcdd}), 32'd0);
    end
    cls = 1'b0;
    t_next = cyc + int'(P_PW + P_ES);

    exp_nib("init0", 1'b0, 4'h3, P_IWL);
    exp_nib("init1", 1'b0, 4'h3, P_IWS);
    exp_nib("init2", 1'b0, 4'h3, P_CMD);
    exp_nib("init3", 1'b0, 4'h2, P_CMD);
    exp_cmd("fnset", 8'h28, P_CMD);
    exp_cmd("disp",  DISP,  P_CMD);
    exp_cmd("entry", 8'h06, P_CMD);
    exp_cmd("clear", 8'h01, P_CLR);

    run_frame(s0, -1, s0);
    s1 = s0;
    s1[255:248] = 8'h41;
    run_frame(s1, -1, s1);
    rand_str(s2);
    run_frame(s2, -1, s2);
    rand_str(s3);
    rand_str(s4);
    tj = int'($urandom_range(0, 31));
    run_frame(s3, tj, s4);

    found = 1'b0;
    for (int n = 0; n < 400 && !found; n++) begin
      @(negedge CCLK);
      if (elcd === 1'b1) found = 1'b1;
    end
    check("abort_e_seen", 32'(found), 32'd1);
    cls = 1'b1;
    @(negedge CCLK);
    check("abort_out", 32'({elcd, rslcd, rwlcd, lcdd}), 32'd0);
    cls = 1'b0;
    t_next    = cyc + int'(P_PW + P_ES);
    prev_e    = elcd;
    prev_lcdd = lcdd;
    exp_nib("reinit0", 1'b0, 4'h3, P_IWL);
    exp_nib("reinit1", 1'b0, 4'h3, P_IWS);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
